// File: rtl/sp_mem_arbiter.sv
// Scratchpad memory-port arbiter: round-robin between load read bursts
// and store write bursts of ROWS beats each, with load back-pressure.
module sp_mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int BITS_PER_ROW = 64,
  parameter int ROWS         = 4,
  parameter int ROW_S_W      = 2,
  parameter int ROW_STRIDE   = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ld_req,
  input  logic [WORD_W-1:0]       ld_addr,
  input  logic                    ld_stall,
  output logic                    ld_rvalid,
  output logic [BITS_PER_ROW-1:0] ld_rdata,
  output logic [ROW_S_W-1:0]      ld_row,
  output logic                    ld_done,
  input  logic                    st_req,
  input  logic [WORD_W-1:0]       st_addr,
  input  logic [BITS_PER_ROW-1:0] st_wdata,
  output logic                    st_wready,
  output logic [ROW_S_W-1:0]      st_row,
  output logic                    st_done,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [WORD_W-1:0]       mem_addr,
  output logic [BITS_PER_ROW-1:0] mem_wdata,
  input  logic [BITS_PER_ROW-1:0] mem_rdata,
  input  logic                    mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_S_W-1:0]  beat_q, beat_d;
  logic [WORD_W-1:0]   base_q, base_d;
  logic                last_st_q, last_st_d;
  logic                last_beat;
  logic [WORD_W-1:0]   beat_addr;

  assign last_beat = (beat_q == ROW_S_W'(ROWS - 1));
  assign beat_addr = base_q
                   + WORD_W'(beat_q) * WORD_W'(ROW_STRIDE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      last_st_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      last_st_q <= last_st_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    last_st_d = last_st_q;
    ld_rvalid = 1'b0;
    ld_rdata  = '0;
    ld_row    = '0;
    ld_done   = 1'b0;
    st_wready = 1'b0;
    st_row    = '0;
    st_done   = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        // last_st_q breaks ties toward whoever was not served last
        if (ld_req && (!st_req || last_st_q)) begin
          state_d = LOAD;
          base_d  = ld_addr;
          beat_d  = '0;
        end else if (st_req) begin
          state_d = STORE;
          base_d  = st_addr;
          beat_d  = '0;
        end
      end
      LOAD: begin
        mem_ren  = ~ld_stall;
        mem_addr = beat_addr;
        ld_row   = beat_q;
        if (!ld_stall && mem_ready) begin
          ld_rvalid = 1'b1;
          ld_rdata  = mem_rdata;
          if (last_beat) begin
            ld_done   = 1'b1;
            state_d   = IDLE;
            last_st_d = 1'b0;
          end else begin
            beat_d = beat_q + ROW_S_W'(1);
          end
        end
      end
      STORE: begin
        mem_wen   = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = st_wdata;
        st_row    = beat_q;
        st_wready = mem_ready;
        if (mem_ready) begin
          if (last_beat) begin
            st_done   = 1'b1;
            state_d   = IDLE;
            last_st_d = 1'b1;
          end else begin
            beat_d = beat_q + ROW_S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Scoreboard bench for sp_mem_arbiter: directed bursts push expected
// memory accesses; a negedge monitor pops and compares each strobe.
module tb_sp_mem_arbiter;

  logic        CLK, RST;
  logic        ld_req, ld_stall, ld_rvalid, ld_done;
  logic [31:0] ld_addr;
  logic [63:0] ld_rdata;
  logic [1:0]  ld_row, st_row;
  logic        st_req, st_wready, st_done;
  logic [31:0] st_addr;
  logic [63:0] st_wdata;
  logic        mem_ren, mem_wen, mem_ready;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  sp_mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ld_row(ld_row), .ld_done(ld_done),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_wready(st_wready), .st_row(st_row), .st_done(st_done),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  typedef struct {
    string       nm;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  row;
    logic        ack;
    logic        done;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t mk(string nm, logic ren, logic wen,
                              logic [31:0] a, logic [1:0] r,
                              logic ack, logic done,
                              logic [63:0] d);
    exp_t e;
    e.nm = nm; e.ren = ren; e.wen = wen; e.addr = a;
    e.row = r; e.ack = ack; e.done = done; e.data = d;
    return e;
  endfunction

  function automatic exp_t act();
    return mk("dut", mem_ren, mem_wen, mem_addr,
              ld_row | st_row, ld_rvalid | st_wready,
              ld_done | st_done, ld_rdata | mem_wdata);
  endfunction

  task automatic check(input exp_t e);
    exp_t a;
    a = act();
    n_cmp++;
    if (a.ren !== e.ren || a.wen !== e.wen || a.addr !== e.addr ||
        a.row !== e.row || a.ack !== e.ack || a.done !== e.done ||
        a.data !== e.data) begin
      n_bad++;
      $display("FAIL %s: got ren=%b wen=%b addr=%h row=%0d ack=%b done=%b data=%h want ren=%b wen=%b addr=%h row=%0d ack=%b done=%b data=%h",
               e.nm, a.ren, a.wen, a.addr, a.row, a.ack, a.done,
               a.data, e.ren, e.wen, e.addr, e.row, e.ack, e.done,
               e.data);
    end
  endtask

  always @(negedge CLK) begin
    if (mem_ren === 1'b1 || mem_wen === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got ren=%b wen=%b addr=%h want no access",
                 mem_ren, mem_wen, mem_addr);
      end else begin
        check(sb.pop_front());
      end
    end
  end

  task automatic cyc(input exp_t e, input bit strobe);
    if (strobe) sb.push_back(e);
    @(negedge CLK);
    if (!strobe) check(e);
    @(posedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no access want ren=%b wen=%b addr=%h",
               sb[0].nm, sb[0].ren, sb[0].wen, sb[0].addr);
      sb.delete();
    end
  endtask

  task automatic idle(input string nm);
    cyc(mk(nm, 0, 0, 32'h0, 2'd0, 0, 0, 64'h0), 1'b0);
  endtask

  task automatic ldb(input string nm, input logic [31:0] a,
                     input logic [1:0] r, input logic done,
                     input logic [63:0] d);
    mem_rdata = d;
    mem_ready = 1'b1;
    cyc(mk(nm, 1, 0, a, r, 1, done, d), 1'b1);
  endtask

  task automatic stb(input string nm, input logic [31:0] a,
                     input logic [1:0] r, input logic rdy,
                     input logic done, input logic [63:0] w);
    st_wdata  = w;
    mem_ready = rdy;
    cyc(mk(nm, 0, 1, a, r, rdy, done, w), 1'b1);
  endtask

  task automatic ld_burst(input string nm, input logic [31:0] base,
                          input logic [63:0] seed);
    for (int i = 0; i < 4; i++)
      ldb(nm, base + 32'(i * 8), 2'(i), i == 3, seed + 64'(i));
  endtask

  task automatic st_burst(input string nm, input logic [31:0] base,
                          input logic [63:0] seed);
    for (int i = 0; i < 4; i++)
      stb(nm, base + 32'(i * 8), 2'(i), 1'b1, i == 3,
          seed + 64'(i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    ld_req = 0; ld_addr = '0; ld_stall = 0;
    st_req = 0; st_addr = '0; st_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle("reset_state");

    // single load burst, memory always ready
    ld_req = 1; ld_addr = 32'h100; mem_ready = 1;
    idle("t1_grant");
    ld_burst("t1_ld", 32'h100, 64'hA100_0000_0000_0000);
    ld_req = 0;
    idle("t1_gap");

    // store burst with 3 wait cycles on the second beat
    st_req = 1; st_addr = 32'h200;
    idle("t2_grant");
    stb("t2_b0", 32'h200, 2'd0, 1, 0, 64'h5700);
    repeat (3) stb("t2_wait", 32'h208, 2'd1, 0, 0, 64'h5701);
    stb("t2_b1", 32'h208, 2'd1, 1, 0, 64'h5701);
    stb("t2_b2", 32'h210, 2'd2, 1, 0, 64'h5702);
    stb("t2_b3", 32'h218, 2'd3, 1, 1, 64'h5703);
    st_req = 0;
    idle("t2_gap");

    // both held: load, store, load
    ld_req = 1; ld_addr = 32'h300;
    st_req = 1; st_addr = 32'h400;
    idle("t3_g0");
    ld_burst("t3_ld0", 32'h300, 64'hB300);
    idle("t3_g1");
    st_burst("t3_st", 32'h400, 64'hC400);
    idle("t3_g2");
    ld_burst("t3_ld1", 32'h300, 64'hD300);
    ld_req = 0; st_req = 0;
    idle("t3_end");
    idle("t3_quiet");

    // back-pressure on beat 2
    ld_req = 1; ld_addr = 32'h100;
    idle("t4_grant");
    ldb("t4_b0", 32'h100, 2'd0, 0, 64'hE0);
    ldb("t4_b1", 32'h108, 2'd1, 0, 64'hE1);
    ld_stall = 1; mem_ready = 1; mem_rdata = '0;
    cyc(mk("t4_stall", 0, 0, 32'h110, 2'd2, 0, 0, 64'h0), 1'b0);
    ld_stall = 0;
    ldb("t4_b2", 32'h110, 2'd2, 0, 64'hE2);
    ldb("t4_b3", 32'h118, 2'd3, 1, 64'hE3);
    ld_req = 0;
    idle("t4_gap");

    // address wrap
    ld_req = 1; ld_addr = 32'hFFFF_FFF8;
    idle("t5_grant");
    ld_burst("t5_wrap", 32'hFFFF_FFF8, 64'hF000);
    ld_req = 0;
    idle("t5_gap");

    // reset in the middle of a store, then a tie
    st_req = 1; st_addr = 32'h500;
    idle("t6_grant");
    stb("t6_b0", 32'h500, 2'd0, 1, 0, 64'h6500);
    stb("t6_b1", 32'h508, 2'd1, 1, 0, 64'h6501);
    RST = 1;
    stb("t6_rst", 32'h510, 2'd2, 0, 0, 64'h6502);
    RST = 0;
    ld_req = 1; ld_addr = 32'h600;
    idle("t6_after_rst");
    ld_burst("t6_tie_ld", 32'h600, 64'h7600);
    ld_req = 0; st_req = 0;
    idle("t6_end");

    repeat (2) @(posedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
